// File: rtl/conversor_gray_pkg.sv
// conversor_gray_pkg
// Shared definitions for the binary/Gray conversion engine:
//   - operation codes carried on the 2-bit 'modo' input
//   - bin2gray / gray2bin helpers, written for the widest legal word
//     (ANCHO_MAX bits). Callers zero-extend their operand and truncate the
//     result; zero upper bits leave the low bits of both conversions unchanged.
package conversor_gray_pkg;

    localparam int unsigned ANCHO_MAX = 32;

    localparam logic [1:0] MODO_B2G    = 2'b00;
    localparam logic [1:0] MODO_G2B    = 2'b01;
    localparam logic [1:0] MODO_CONTAR = 2'b10;
    localparam logic [1:0] MODO_CARGAR = 2'b11;

    // Binary to Gray: each bit is XORed with its more significant neighbour.
    function automatic logic [ANCHO_MAX-1:0] bin2gray(input logic [ANCHO_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: running XOR from the MSB downwards.
    function automatic logic [ANCHO_MAX-1:0] gray2bin(input logic [ANCHO_MAX-1:0] g);
        logic [ANCHO_MAX-1:0] b;
        b = '0;
        b[ANCHO_MAX-1] = g[ANCHO_MAX-1];
        for (int i = ANCHO_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/contador_gray.sv
// contador_gray
// Binary up/down counter that presents its *next* value in Gray code.
// The registered count stays binary; only the combinational look-ahead is
// converted, so the parent can register the Gray word in the same cycle the
// count advances.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high; clears the count
//   en                  advance (or load) the count at the next edge
//   cargar              1: next count = valor; 0: next count = count +/- 1
//   arriba              direction when not loading: 1 up, 0 down
//   valor               load value (binary)
//   cnt_gray_siguiente  Gray code of the next count
//   vuelta              next step wraps (all-ones -> 0 up, 0 -> all-ones down)
module contador_gray
    import conversor_gray_pkg::*;
#(
    parameter int unsigned ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cargar,
    input  logic             arriba,
    input  logic [ANCHO-1:0] valor,
    output logic [ANCHO-1:0] cnt_gray_siguiente,
    output logic             vuelta
);

    localparam logic [ANCHO-1:0] TODO_UNOS = '1;
    localparam logic [ANCHO-1:0] UNO       = ANCHO'(1);

    logic [ANCHO-1:0] cnt_q;
    logic [ANCHO-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        vuelta = 1'b0;
        if (cargar) begin
            cnt_d = valor;
        end else if (arriba) begin
            cnt_d  = cnt_q + UNO;
            // Wrap taken from the pre-update value, not from a carry-out.
            vuelta = (cnt_q == TODO_UNOS);
        end else begin
            cnt_d  = cnt_q - UNO;
            vuelta = (cnt_q == '0);
        end
    end

    assign cnt_gray_siguiente = ANCHO'(bin2gray(ANCHO_MAX'(cnt_d)));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conversor_gray_param.sv
// conversor_gray_param
// Registered binary/Gray conversion engine with an integrated Gray counter.
// One request is accepted per cycle through a valid/ready handshake and its
// result is held in a single output register until the consumer takes it.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   modo        operation: 00 B2G, 01 G2B, 10 CONTAR, 11 CARGAR
//   arriba      count direction in CONTAR (1 up, 0 down)
//   dato_in     operand word (ignored in CONTAR)
//   valido_in   request valid
//   listo_in    block can accept a request this cycle
//   dato_out    result word
//   vuelta_out  result came from a counter wrap (qualified by valido_out)
//   valido_out  result valid
//   listo_out   consumer accepts the result
module conversor_gray_param
    import conversor_gray_pkg::*;
#(
    parameter int unsigned ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       modo,
    input  logic             arriba,
    input  logic [ANCHO-1:0] dato_in,
    input  logic             valido_in,
    output logic             listo_in,
    output logic [ANCHO-1:0] dato_out,
    output logic             vuelta_out,
    output logic             valido_out,
    input  logic             listo_out
);

    logic             xfer_in;
    logic             xfer_out;

    logic             cnt_en;
    logic             cnt_cargar;
    logic [ANCHO-1:0] cnt_gray;
    logic             cnt_vuelta;

    logic [ANCHO-1:0] res_dato;
    logic             res_vuelta;

    logic [ANCHO-1:0] dato_q;
    logic             vuelta_q;
    logic             valido_q;

    // Ready whenever the output register is empty or being drained now.
    assign listo_in = !valido_q || listo_out;
    // Requests presented during reset are never accepted.
    assign xfer_in  = valido_in && listo_in && !reset;
    assign xfer_out = valido_q && listo_out;

    // Both counter modes have modo[1] set.
    assign cnt_en     = xfer_in && modo[1];
    assign cnt_cargar = (modo == MODO_CARGAR);

    contador_gray #(
        .ANCHO(ANCHO)
    ) u_contador (
        .clk                (clk),
        .reset              (reset),
        .en                 (cnt_en),
        .cargar             (cnt_cargar),
        .arriba             (arriba),
        .valor              (dato_in),
        .cnt_gray_siguiente (cnt_gray),
        .vuelta             (cnt_vuelta)
    );

    always_comb begin
        res_dato   = '0;
        res_vuelta = 1'b0;
        case (modo)
            MODO_B2G: res_dato = ANCHO'(bin2gray(ANCHO_MAX'(dato_in)));
            MODO_G2B: res_dato = ANCHO'(gray2bin(ANCHO_MAX'(dato_in)));
            MODO_CONTAR: begin
                res_dato   = cnt_gray;
                res_vuelta = cnt_vuelta;
            end
            // CARGAR: the counter look-ahead already equals Gray(dato_in).
            default: res_dato = cnt_gray;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dato_q   <= '0;
            vuelta_q <= 1'b0;
            valido_q <= 1'b0;
        end else if (xfer_in) begin
            // Covers the simultaneous in/out case: new result replaces old.
            dato_q   <= res_dato;
            vuelta_q <= res_vuelta;
            valido_q <= 1'b1;
        end else if (xfer_out) begin
            valido_q <= 1'b0;
        end
    end

    assign dato_out   = dato_q;
    assign vuelta_out = vuelta_q;
    assign valido_out = valido_q;

endmodule

// File: tb/tb_conversor_gray_param.sv
module tb_conversor_gray_param;
    import conversor_gray_pkg::*;

    localparam int unsigned ANCHO = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       modo;
    logic             arriba;
    logic [ANCHO-1:0] dato_in;
    logic             valido_in;
    logic             listo_in;
    logic [ANCHO-1:0] dato_out;
    logic             vuelta_out;
    logic             valido_out;
    logic             listo_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conversor_gray_param #(
        .ANCHO(ANCHO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .modo       (modo),
        .arriba     (arriba),
        .dato_in    (dato_in),
        .valido_in  (valido_in),
        .listo_in   (listo_in),
        .dato_out   (dato_out),
        .vuelta_out (vuelta_out),
        .valido_out (valido_out),
        .listo_out  (listo_out)
    );

    typedef struct {
        string      nombre;
        logic [1:0] modo;
        logic       arriba;
        logic [3:0] dato;
        logic [3:0] exp_dato;
        logic       exp_vuelta;
    } vec_t;

    vec_t tabla[13];

    task automatic check(input string nombre, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nombre, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic pedir(input logic [1:0] m, input logic a, input logic [3:0] d);
        modo      = m;
        arriba    = a;
        dato_in   = d;
        valido_in = 1'b1;
    endtask

    task automatic aplicar_reset();
        reset     = 1'b1;
        valido_in = 1'b0;
        paso();
        reset = 1'b0;
    endtask

    logic [3:0] prev_g;
    logic [3:0] g;

    initial begin
        tabla[0]  = '{"b2g_1011",    MODO_B2G,    1'b0, 4'b1011, 4'b1110, 1'b0};
        tabla[1]  = '{"g2b_1000",    MODO_G2B,    1'b0, 4'b1000, 4'b1111, 1'b0};
        tabla[2]  = '{"g2b_0110",    MODO_G2B,    1'b0, 4'b0110, 4'b0100, 1'b0};
        tabla[3]  = '{"b2g_1111",    MODO_B2G,    1'b0, 4'b1111, 4'b1000, 1'b0};
        tabla[4]  = '{"g2b_1111",    MODO_G2B,    1'b0, 4'b1111, 4'b1010, 1'b0};
        tabla[5]  = '{"load_1111",   MODO_CARGAR, 1'b0, 4'b1111, 4'b1000, 1'b0};
        tabla[6]  = '{"up_wrap",     MODO_CONTAR, 1'b1, 4'b0000, 4'b0000, 1'b1};
        tabla[7]  = '{"down_wrap",   MODO_CONTAR, 1'b0, 4'b0000, 4'b1000, 1'b1};
        tabla[8]  = '{"down_1110",   MODO_CONTAR, 1'b0, 4'b0101, 4'b1001, 1'b0};
        tabla[9]  = '{"b2g_0101",    MODO_B2G,    1'b1, 4'b0101, 4'b0111, 1'b0};
        tabla[10] = '{"up_1111",     MODO_CONTAR, 1'b1, 4'b0011, 4'b1000, 1'b0};
        tabla[11] = '{"load_0101",   MODO_CARGAR, 1'b1, 4'b0101, 4'b0111, 1'b0};
        tabla[12] = '{"up_0110",     MODO_CONTAR, 1'b1, 4'b1111, 4'b0101, 1'b0};

        reset     = 1'b1;
        modo      = MODO_B2G;
        arriba    = 1'b0;
        dato_in   = '0;
        valido_in = 1'b0;
        listo_out = 1'b1;
        paso();
        paso();

        // Reset state; ready is high even while reset is asserted.
        check("rst_valido", 32'(valido_out), 32'd0);
        check("rst_dato", 32'(dato_out), 32'd0);
        check("rst_vuelta", 32'(vuelta_out), 32'd0);
        check("rst_listo_in", 32'(listo_in), 32'd1);
        reset = 1'b0;

        // Table: back-to-back transfers, each result one edge later.
        for (int i = 0; i < 13; i++) begin
            pedir(tabla[i].modo, tabla[i].arriba, tabla[i].dato);
            paso();
            check({tabla[i].nombre, "_dato"}, 32'(dato_out), 32'(tabla[i].exp_dato));
            check({tabla[i].nombre, "_vuelta"}, 32'(vuelta_out), 32'(tabla[i].exp_vuelta));
            check({tabla[i].nombre, "_valido"}, 32'(valido_out), 32'd1);
        end
        valido_in = 1'b0;
        paso();
        check("drain_valido", 32'(valido_out), 32'd0);

        // B2G sweep: adjacent codes differ in exactly one bit; round trip via G2B.
        prev_g = '0;
        for (int x = 0; x < 16; x++) begin
            pedir(MODO_B2G, 1'b0, 4'(x));
            paso();
            g = dato_out;
            if (x > 0) check($sformatf("sweep_hamming_%0d", x), 32'($countones(g ^ prev_g)), 32'd1);
            prev_g = g;
            pedir(MODO_G2B, 1'b0, g);
            paso();
            check($sformatf("roundtrip_%0d", x), 32'(dato_out), 32'(x));
        end
        valido_in = 1'b0;
        paso();

        // Count after reset: 0001, 0011, 0010 with no bubble.
        aplicar_reset();
        pedir(MODO_CONTAR, 1'b1, 4'b0000);
        paso();
        check("cnt1_dato", 32'(dato_out), 32'b0001);
        check("cnt1_listo_in", 32'(listo_in), 32'd1);
        paso();
        check("cnt2_dato", 32'(dato_out), 32'b0011);
        check("cnt2_valido", 32'(valido_out), 32'd1);
        paso();
        check("cnt3_dato", 32'(dato_out), 32'b0010);
        check("cnt3_valido", 32'(valido_out), 32'd1);
        valido_in = 1'b0;
        paso();

        // Backpressure: result and counter hold while listo_out=0.
        aplicar_reset();
        listo_out = 1'b0;
        pedir(MODO_CONTAR, 1'b1, 4'b0000);
        paso();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_listo_in_%0d", c), 32'(listo_in), 32'd0);
            check($sformatf("bp_dato_%0d", c), 32'(dato_out), 32'b0001);
            check($sformatf("bp_valido_%0d", c), 32'(valido_out), 32'd1);
            paso();
        end
        listo_out = 1'b1;
        paso();
        check("bp_release_dato", 32'(dato_out), 32'b0011);
        check("bp_release_valido", 32'(valido_out), 32'd1);
        valido_in = 1'b0;
        paso();
        check("bp_drain", 32'(valido_out), 32'd0);

        // Reset mid-operation with a pending result and cnt=9.
        listo_out = 1'b0;
        pedir(MODO_CARGAR, 1'b0, 4'b1001);
        paso();
        check("mid_load_dato", 32'(dato_out), 32'b1101);
        pedir(MODO_CONTAR, 1'b1, 4'b0000);
        reset = 1'b1;
        paso();
        check("mid_rst_valido", 32'(valido_out), 32'd0);
        check("mid_rst_dato", 32'(dato_out), 32'd0);
        // A request during a reset cycle must not be taken.
        listo_out = 1'b1;
        #1;
        check("mid_rst_listo_in", 32'(listo_in), 32'd1);
        paso();
        check("mid_rst_noaccept", 32'(valido_out), 32'd0);
        reset = 1'b0;
        paso();
        check("mid_after_dato", 32'(dato_out), 32'b0001);
        check("mid_after_valido", 32'(valido_out), 32'd1);
        valido_in = 1'b0;
        paso();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conversor_gray_param.md
# conversor_gray_param

Parametrised, registered binary/Gray conversion engine with an integrated Gray-code up/down counter. It converts ANCHO-bit words in either direction (binary→Gray, Gray→binary), or generates a Gray count sequence with load and wrap detection. Input and output use valid/ready handshakes and a one-entry output register. It sits between sequential producers, such as position encoders or pointer logic, and consumers that need Gray or binary words with flow control.

## Interface
- ANCHO, 4: data width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  reset, synchronous and active-high.
- modo  input  2  operation, sampled on input acceptance: 00 B2G, 01 G2B, 10 CONTAR, 11 CARGAR.
- arriba  input  1  count direction in CONTAR, sampled on acceptance: 1 increment, 0 decrement.
- dato_in  input  ANCHO  operand word; ignored in CONTAR.
- valido_in  input  1  operand/request valid.
- listo_in  output  1  block can accept this cycle.
- dato_out  output  ANCHO  result word.
- vuelta_out  output  1  result produced by a counter wrap; qualified by valido_out.
- valido_out  output  1  result valid.
- listo_out  input  1  downstream accepts the result.

## Operation
- Transfers:
  - Input transfer occurs when valido_in && listo_in.
  - Output transfer occurs when valido_out && listo_out.
- listo_in = !valido_out || listo_out. This is combinational, giving full throughput of one word per cycle.
- On an input transfer, the result is registered into dato_out and vuelta_out, and valido_out is set.
- On an output transfer with no input transfer in the same cycle, valido_out clears.
- B2G: dato_out = dato_in ^ (dato_in >> 1). vuelta_out = 0. The counter is unchanged.
- G2B: dato_out[ANCHO-1] = dato_in[ANCHO-1]; dato_out[i] = dato_out[i+1] ^ dato_in[i], for i from ANCHO-2 down to 0. vuelta_out = 0. The counter is unchanged.
- CONTAR: the internal binary counter cnt updates to cnt+1 (arriba=1) or cnt-1 (arriba=0), modulo 2^ANCHO.
  - dato_out = Gray of the updated cnt.
  - vuelta_out = 1 when an increment goes from all-ones to 0, or a decrement goes from 0 to all-ones; otherwise 0.
- CARGAR: cnt is set to dato_in (binary). dato_out = Gray of dato_in. vuelta_out = 0.
- cnt changes only on input transfers in CONTAR or CARGAR. Mode changes between transfers never disturb cnt.
- Backpressure: while valido_out=1 and listo_out=0:
  - dato_out and vuelta_out hold stable;
  - listo_in = 0;
  - cnt does not advance.
- Inputs without a transfer (valido_in=0, or listo_in=0) have no effect on any state.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on dato_out with valido_out=1 after edge N.
- Simultaneous output and input transfer in one cycle: the new result replaces the old one; valido_out stays 1. No bubble.
- Reset values: valido_out = 0, dato_out = 0, vuelta_out = 0, cnt = 0.
- While reset is high, listo_in = 1 (valido_out is 0). However, no input transfer takes effect during a reset cycle.
- Reset asserted mid-operation takes effect at the next edge. A pending, unconsumed result is discarded. The next CONTAR with arriba=1 then yields Gray(1).
- No internal FSM beyond the valido_out flag. The output register is either EMPTY (valido_out=0) or FULL (valido_out=1). Transitions:
  - EMPTY to FULL on an input transfer.
  - FULL to EMPTY on an output-only transfer.
  - FULL stays FULL on a simultaneous input and output transfer.
- All arithmetic is unsigned ANCHO-bit. Wrap is detected by comparing cnt against all-ones or zero before the update, not from a carry-out bit.

## Structure
- Shared package conversor_gray_pkg:
  - mode localparams MODO_B2G = 2'b00, MODO_G2B = 2'b01, MODO_CONTAR = 2'b10, MODO_CARGAR = 2'b11;
  - functions bin2gray and gray2bin, parametrised via width argument or loop bound ANCHO.
- One sub-module: contador_gray. It holds cnt and has inputs en, cargar, arriba and valor. Its outputs are cnt_gray_siguiente and vuelta, computed combinationally from the next count.
- The top level holds the handshake and output register, and the mode multiplexer.

## Test plan
- ANCHO=4, B2G:
  - dato_in=4'b1011 → dato_out=4'b1110, vuelta_out=0, one cycle later.
  - Sweep 0..15: every adjacent pair of outputs differs in exactly one bit.
- ANCHO=4, G2B:
  - dato_in=4'b1000 → 4'b1111.
  - dato_in=4'b0110 → 4'b0100.
  - Round trip: G2B(B2G(x)) == x for all 16 values.
- Counting after reset, three CONTAR requests with arriba=1, listo_out=1 → outputs 0001, 0011, 0010 on back-to-back cycles, with no bubble.
- Wrap:
  - CARGAR 4'b1111 → dato_out=1000.
  - Then CONTAR up → dato_out=0000, vuelta_out=1.
  - Then CONTAR down → dato_out=1000, vuelta_out=1.
- Backpressure: hold listo_out=0 for 5 cycles with valido_in=1 in CONTAR up →
  - listo_in=0;
  - dato_out is stable at the first result;
  - cnt has advanced exactly once.
  - After release, the next result is the following count.
- Reset mid-operation: assert reset with valido_out=1 and cnt=9 → next cycle valido_out=0, dato_out=0. A subsequent CONTAR up yields 0001.
